// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the buffered 1-to-2 demultiplexer.
//   DATA_W     : default data word width
//   FIFO_DEPTH : default entries per channel FIFO (power of two, >= 2)
//   data_t     : data word type at the default width
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 2;

    typedef logic [DATA_W-1:0] data_t;

endpackage : demux_pkg

// File: rtl/demux_buffered_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered occupancy count. Head word is presented
// combinationally from storage (first-word fall-through), so a word written at
// edge N is readable right after edge N.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   wr_en      : write request, ignored when full
//   wr_data    : word to write
//   rd_en      : read (pop) request, ignored when empty
//   rd_data    : head word
//   full       : count == DEPTH
//   empty      : count == 0
//   count      : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_r;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == '0);

    // A write into a full FIFO is refused even if a read happens this cycle.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Pointers are exactly AW bits wide, so they wrap DEPTH-1 -> 0 by overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage is cleared on reset so the head output reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign count   = count_r;

endmodule : sync_fifo

// File: rtl/demux_buffered.sv
// -----------------------------------------------------------------------------
// demux_buffered
// Buffered 1-to-2 demultiplexer. A word accepted over the input valid/ready
// handshake is queued in the FIFO of the channel named by selecter; each
// channel drains independently, so a stalled consumer only blocks its own
// channel.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   inputdata, selecter : word and destination channel (0 or 1)
//   in_valid, in_ready  : input handshake
//   outputdata_k        : channel k head word
//   out_valid_k         : channel k holds at least one word
//   out_ready_k         : channel k consumer takes the head word
//   count_k             : channel k occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module demux_buffered
    import demux_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         inputdata,
    input  logic                     selecter,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         outputdata_0,
    output logic                     out_valid_0,
    input  logic                     out_ready_0,
    output logic [WIDTH-1:0]         outputdata_1,
    output logic                     out_valid_1,
    input  logic                     out_ready_1,
    output logic [$clog2(DEPTH):0]   count_0,
    output logic [$clog2(DEPTH):0]   count_1
);

    logic full_0;
    logic full_1;
    logic empty_0;
    logic empty_1;
    logic push;
    logic wr_en_0;
    logic wr_en_1;
    logic pop_0;
    logic pop_1;

    // Ready looks only at the addressed channel's registered fullness, never at
    // the consumers, so there is no full-bypass through a same-cycle pop.
    assign in_ready = rst_n && (selecter ? !full_1 : !full_0);

    assign push    = in_valid && in_ready;
    assign wr_en_0 = push && !selecter;
    assign wr_en_1 = push &&  selecter;

    assign out_valid_0 = !empty_0;
    assign out_valid_1 = !empty_1;
    assign pop_0       = out_valid_0 && out_ready_0;
    assign pop_1       = out_valid_1 && out_ready_1;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_0),
        .wr_data (inputdata),
        .rd_en   (pop_0),
        .rd_data (outputdata_0),
        .full    (full_0),
        .empty   (empty_0),
        .count   (count_0)
    );

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_1),
        .wr_data (inputdata),
        .rd_en   (pop_1),
        .rd_data (outputdata_1),
        .full    (full_1),
        .empty   (empty_1),
        .count   (count_1)
    );

endmodule : demux_buffered
